// File: rtl/arith_pkg.sv
// Shared arithmetic types for the bit-serial datapath.
// Holds the subtractor FSM encoding and default width.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Host-side start/busy/done bundle for serial_subtractor.
// master = host, slave = subtractor.
interface serial_subtractor_if
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin.
// Purely combinational.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock.
// Result and borrow are held until the next operation finishes.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  sub_state_t state;
  sub_state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;
  logic             last;

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (brw),
    .diff (d),
    .bout (bo)
  );

  assign last  = (cnt == CNT_W'(WIDTH - 1));
  // Shift-in at the MSB; written this way so WIDTH=1 needs no special case.
  assign r_nxt = (r_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Result is captured from the final bit so it lands with done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      brw  <= bus.bin;
      cnt  <= '0;
    end else if (state == SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_nxt;
      brw  <= bo;
      cnt  <= cnt + CNT_W'(1);
      if (last) begin
        diff_q <= r_nxt;
        bout_q <= bo;
      end
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Stimulus pushes expected results; monitors pop on done.
module tb_serial_subtractor;
  typedef struct {
    logic [7:0] d;
    logic       b;
  } exp8_t;

  typedef struct {
    logic d;
    logic b;
  } exp1_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   done8_cnt;
  exp8_t q8[$];
  exp1_t q1[$];

  serial_subtractor_if #(.WIDTH(8)) sb8 ();
  serial_subtractor_if #(.WIDTH(1)) sb1 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    exp8_t e;
    if (sb8.done === 1'b1) begin
      done8_cnt++;
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("diff8", 32'(sb8.diff), 32'(e.d));
        chk("bout8", 32'(sb8.bout), 32'(e.b));
      end
    end
  end

  always @(negedge clk) begin
    exp1_t e;
    if (sb1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("done1_unexpected", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("diff1", 32'(sb1.diff), 32'(e.d));
        chk("bout1", 32'(sb1.bout), 32'(e.b));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input bit push,
                        input logic [7:0] ed, input logic eb);
    exp8_t e;
    sb8.start = 1'b1;
    sb8.a     = a;
    sb8.b     = b;
    sb8.bin   = bin;
    if (push) begin
      e.d = ed;
      e.b = eb;
      q8.push_back(e);
    end
    cyc(1);
    sb8.start = 1'b0;
    sb8.a     = 8'hA5;
    sb8.b     = 8'h5A;
    sb8.bin   = 1'b1;
  endtask

  task automatic wait_done8();
    int k;
    k = 0;
    while (sb8.done !== 1'b1 && k < 30) begin
      cyc(1);
      k++;
    end
    chk("done8_timeout", 32'(sb8.done), 32'd1);
  endtask

  initial begin
    logic [7:0] tt_d;
    logic [7:0] tt_b;
    exp1_t      e1;
    int         d0;

    tests     = 0;
    fails     = 0;
    done8_cnt = 0;
    rst_n     = 1'b0;
    sb8.start = 1'b0;
    sb8.a     = '0;
    sb8.b     = '0;
    sb8.bin   = 1'b0;
    sb1.start = 1'b0;
    sb1.a     = '0;
    sb1.b     = '0;
    sb1.bin   = 1'b0;

    cyc(3);
    chk("rst_busy", 32'(sb8.busy), 32'd0);
    chk("rst_done", 32'(sb8.done), 32'd0);
    chk("rst_diff", 32'(sb8.diff), 32'd0);
    chk("rst_bout", 32'(sb8.bout), 32'd0);
    chk("rst_busy1", 32'(sb1.busy), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // Basic timing: busy cycles 1..8, done cycle 9
    issue8(8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      chk("t1_busy", 32'(sb8.busy), 32'd1);
      chk("t1_done_early", 32'(sb8.done), 32'd0);
      cyc(1);
    end
    chk("t1_done", 32'(sb8.done), 32'd1);
    chk("t1_busy_off", 32'(sb8.busy), 32'd0);
    cyc(1);

    // Underflow wrap cases
    issue8(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    wait_done8();
    cyc(1);
    issue8(8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b1);
    wait_done8();
    cyc(1);

    // Start while busy / in DONE is ignored
    d0 = done8_cnt;
    issue8(8'h80, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0);
    cyc(2);
    sb8.start = 1'b1;
    sb8.a     = 8'h01;
    sb8.b     = 8'h01;
    cyc(1);
    sb8.start = 1'b0;
    cyc(5);
    chk("t3_done9", 32'(sb8.done), 32'd1);
    sb8.start = 1'b1;
    cyc(1);
    sb8.start = 1'b0;
    cyc(15);
    chk("t3_one_done", 32'(done8_cnt - d0), 32'd1);

    // Back-to-back with start held high
    issue8(8'h0F, 8'h01, 1'b0, 1'b1, 8'h0E, 1'b0);
    sb8.start = 1'b1;
    sb8.a     = 8'hFF;
    sb8.b     = 8'hFE;
    sb8.bin   = 1'b0;
    begin
      exp8_t e;
      e.d = 8'h01;
      e.b = 1'b0;
      q8.push_back(e);
    end
    cyc(8);
    chk("t4_done9", 32'(sb8.done), 32'd1);
    cyc(1);
    for (int c = 10; c <= 18; c++) begin
      chk("t4_hold", 32'(sb8.diff), 32'h0E);
      chk("t4_no_done", 32'(sb8.done), 32'd0);
      cyc(1);
      if (c == 10) sb8.start = 1'b0;
    end
    chk("t4_done19", 32'(sb8.done), 32'd1);
    cyc(1);

    // Reset mid-operation aborts
    issue8(8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(3);
    rst_n = 1'b0;
    cyc(1);
    chk("t5_busy", 32'(sb8.busy), 32'd0);
    chk("t5_done", 32'(sb8.done), 32'd0);
    chk("t5_diff", 32'(sb8.diff), 32'd0);
    chk("t5_bout", 32'(sb8.bout), 32'd0);
    rst_n = 1'b1;
    d0 = done8_cnt;
    cyc(15);
    chk("t5_no_done", 32'(done8_cnt - d0), 32'd0);
    issue8(8'h33, 8'h11, 1'b0, 1'b1, 8'h22, 1'b0);
    wait_done8();
    cyc(1);

    // WIDTH=1 truth table, index = {a,b,bin}
    tt_d = 8'b1001_0110;
    tt_b = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      sb1.start = 1'b1;
      sb1.a     = 1'(i >> 2);
      sb1.b     = 1'(i >> 1);
      sb1.bin   = 1'(i);
      e1.d      = tt_d[i];
      e1.b      = tt_b[i];
      q1.push_back(e1);
      cyc(1);
      sb1.start = 1'b0;
      chk("w1_busy", 32'(sb1.busy), 32'd1);
      chk("w1_done_early", 32'(sb1.done), 32'd0);
      cyc(1);
      chk("w1_done", 32'(sb1.done), 32'd1);
      cyc(1);
    end

    cyc(3);
    chk("q8_empty", 32'(q8.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
